hwpe_ctrl_jobq: RTL and testbench



---
 rtl/hwpe_ctrl_jobq.sv | 227 ++++++++++++++++++++++
 tb/tb_hwpe_ctrl_jobq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_jobq.sv
// hwpe_ctrl_jobq: multi-context job queue that offloads core jobs to an HWPE engine and routes its events back to the owning core
module hwpe_ctrl_jobq #(
    parameter int unsigned N_CORES      = 8,
    parameter int unsigned N_CONTEXT    = 4,
    parameter int unsigned N_EVT        = 4,
    parameter int unsigned N_SW_EVT     = 8,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned CLEAR_CYCLES = 3,
    localparam int unsigned LC = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_req_i,
    output logic                       cfg_gnt_o,
    input  logic [31:0]                cfg_add_i,
    input  logic                       cfg_wen_i,
    input  logic [31:0]                cfg_data_i,
    input  logic [ID_WIDTH-1:0]        cfg_id_i,
    output logic [31:0]                cfg_r_data_o,
    output logic                       cfg_r_valid_o,
    output logic [ID_WIDTH-1:0]        cfg_r_id_o,
    input  logic                       done_i,
    input  logic [N_EVT-1:1]           evt_i,
    output logic                       start_o,
    output logic                       busy_o,
    output logic [LC-1:0]              ctx_o,
    output logic [LC-1:0]              acq_ctx_o,
    output logic                       locked_o,
    output logic [N_CORES*N_EVT-1:0]   evt_o,
    output logic [N_SW_EVT-1:0]        sw_evt_o,
    output logic                       clear_o
);
    localparam int unsigned CW  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int unsigned PW  = LC + 1;
    localparam int unsigned SWW = (N_SW_EVT > 1) ? $clog2(N_SW_EVT) : 1;
    localparam int unsigned CCW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int unsigned EW  = N_CORES * N_EVT;
    localparam logic [LC-1:0]  LAST       = LC'(N_CONTEXT - 1);
    localparam logic [CCW-1:0] CCNT_INIT  = CCW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, RUN} state_e;

    state_e               state_q;
    logic                 start_q, busy_q;
    logic [LC-1:0]        ctx_q;
    logic [LC-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        pending_q, pending_d;
    logic [CW-1:0]        owner_q [N_CONTEXT];
    logic [CW-1:0]        owner_d [N_CONTEXT];
    logic                 lock_q, lock_d;
    logic [ID_WIDTH-1:0]  lock_id_q, lock_id_d;
    logic [31:0]          finished_q, finished_d;
    logic                 clear_q, clear_d;
    logic [CCW-1:0]       ccnt_q, ccnt_d;
    logic [N_SW_EVT-1:0]  sw_evt_q, sw_evt_d;
    logic [EW-1:0]        evt_q, evt_d;
    logic                 r_valid_q;
    logic [31:0]          r_data_q, r_data_d, status;
    logic [ID_WIDTH-1:0]  r_id_q;

    logic [2:0]     off;
    logic           wr, rd, acq_free, owner_ok, acq_ok, trig_ok, abort_ok;
    logic           clear_start, wipe, done_fire;
    logic [SWW-1:0] sw_idx;
    logic [CW-1:0]  owner_cur;
    logic [N_EVT-1:0] cur_evt;
    logic           unused_bits;

    function automatic logic [LC-1:0] nxt(input logic [LC-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign off         = cfg_add_i[4:2];
    assign wr          = cfg_req_i && !cfg_wen_i;
    assign rd          = cfg_req_i && cfg_wen_i;
    assign acq_free    = !lock_q && (pending_q < PW'(N_CONTEXT)) && !clear_q;
    assign owner_ok    = lock_q && (cfg_id_i == lock_id_q) && !clear_q;
    assign acq_ok      = rd && off == 3'd1 && acq_free;
    assign trig_ok     = wr && off == 3'd0 && owner_ok;
    assign abort_ok    = wr && off == 3'd6 && owner_ok;
    assign clear_start = wr && off == 3'd5 && !clear_q;
    assign wipe        = clear_q || clear_start;
    assign clear_d     = clear_q ? (ccnt_q != '0) : clear_start;
    assign ccnt_d      = clear_q ? ccnt_q - 1'b1 : CCNT_INIT;
    assign done_fire   = (state_q == RUN) && done_i && !wipe;
    assign sw_idx      = cfg_data_i[SWW-1:0];
    assign sw_evt_d    = (wr && off == 3'd7 && 32'(sw_idx) < N_SW_EVT) ? (N_SW_EVT'(1) << sw_idx) : '0;
    assign owner_cur   = owner_q[rd_ptr_q];
    assign cur_evt     = {busy_q ? evt_i : '0, done_fire};
    assign evt_d       = wipe ? '0 : EW'(cur_evt) << (N_EVT * int'(owner_cur));
    assign unused_bits = ^{cfg_add_i[31:5], cfg_add_i[1:0], cfg_data_i[31:SWW]};

    // Queue bookkeeping: lock handshake, owner table, pointers and counters
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        finished_d = finished_q;
        pending_d  = pending_q + PW'(trig_ok) - PW'(done_fire);
        if (acq_ok) begin
            lock_d    = 1'b1;
            lock_id_d = cfg_id_i;
        end
        if (trig_ok) begin
            owner_d[wr_ptr_q] = cfg_id_i[CW-1:0];
            wr_ptr_d          = nxt(wr_ptr_q);
            lock_d            = 1'b0;
        end
        if (abort_ok) lock_d = 1'b0;
        if (done_fire) begin
            rd_ptr_d   = nxt(rd_ptr_q);
            finished_d = finished_q + 32'd1;
        end
        if (wipe) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            owner_d    = '{default: '0};
            lock_d     = 1'b0;
            lock_id_d  = '0;
            finished_d = '0;
            pending_d  = '0;
        end
    end

    // Read-data mux; a failed ACQUIRE answers all-ones, writes answer zero
    always_comb begin
        status         = '0;
        status[LC:0]   = pending_q;
        status[8]      = lock_q;
        status[9]      = busy_q;
        status[31:16]  = 16'(lock_id_q);
        r_data_d       = '0;
        if (rd) begin
            case (off)
                3'd1:    r_data_d = acq_free ? 32'(wr_ptr_q) : '1;
                3'd2:    r_data_d = finished_q;
                3'd3:    r_data_d = status;
                3'd4:    r_data_d = 32'(rd_ptr_q);
                default: r_data_d = '0;
            endcase
        end
    end

    // State, event and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pending_q  <= '0;
            owner_q    <= '{default: '0};
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            finished_q <= '0;
            clear_q    <= 1'b0;
            ccnt_q     <= '0;
            sw_evt_q   <= '0;
            evt_q      <= '0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_id_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pending_q  <= pending_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            finished_q <= finished_d;
            clear_q    <= clear_d;
            ccnt_q     <= ccnt_d;
            sw_evt_q   <= sw_evt_d;
            evt_q      <= evt_d;
            r_valid_q  <= cfg_req_i;
            r_data_q   <= r_data_d;
            r_id_q     <= cfg_req_i ? cfg_id_i : '0;
        end
    end

    // Engine sequencer; busy lingers one cycle after done so back-to-back jobs start three cycles after done
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ctx_q   <= '0;
        end else if (wipe) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ctx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending_q != '0 && !busy_q) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        ctx_q   <= rd_ptr_q;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= RUN;
                end
                RUN: if (done_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_gnt_o     = 1'b1;
    assign cfg_r_data_o  = r_data_q;
    assign cfg_r_valid_o = r_valid_q;
    assign cfg_r_id_o    = r_id_q;
    assign start_o       = start_q;
    assign busy_o        = busy_q;
    assign ctx_o         = ctx_q;
    assign acq_ctx_o     = wr_ptr_q;
    assign locked_o      = lock_q;
    assign evt_o         = evt_q;
    assign sw_evt_o      = sw_evt_q;
    assign clear_o       = clear_q;
endmodule

// File: tb/tb_hwpe_ctrl_jobq.sv
// tb_hwpe_ctrl_jobq: scoreboard bench for the job-queue controller (4-context and 1-context instances)
module tb_hwpe_ctrl_jobq;
    localparam logic [2:0] TRIG = 3'd0, ACQ = 3'd1, FIN = 3'd2, STAT = 3'd3;
    localparam logic [2:0] RUNR = 3'd4, SCLR = 3'd5, ABRT = 3'd6, SWE = 3'd7;

    logic clk = 1'b0, rst_ni = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req0 = 0, req1 = 0, wen = 0, done0 = 0, done1 = 0;
    logic [31:0] add = '0, data = '0;
    logic [7:0]  id = '0;
    logic [3:1]  evt_in = '0;

    logic        gnt0, rvalid0, start0, busy0, locked0, clear0;
    logic [31:0] rdata0, evt0;
    logic [7:0]  rid0, sw0;
    logic [1:0]  ctx0, acq0;
    logic        gnt1, rvalid1, start1, busy1, locked1, clear1;
    logic [31:0] rdata1, evt1;
    logic [7:0]  rid1, sw1;
    logic [0:0]  ctx1, acq1;

    hwpe_ctrl_jobq u0 (
        .clk_i(clk), .rst_ni(rst_ni), .cfg_req_i(req0), .cfg_gnt_o(gnt0), .cfg_add_i(add),
        .cfg_wen_i(wen), .cfg_data_i(data), .cfg_id_i(id), .cfg_r_data_o(rdata0),
        .cfg_r_valid_o(rvalid0), .cfg_r_id_o(rid0), .done_i(done0), .evt_i(evt_in),
        .start_o(start0), .busy_o(busy0), .ctx_o(ctx0), .acq_ctx_o(acq0), .locked_o(locked0),
        .evt_o(evt0), .sw_evt_o(sw0), .clear_o(clear0)
    );

    hwpe_ctrl_jobq #(.N_CONTEXT(1)) u1 (
        .clk_i(clk), .rst_ni(rst_ni), .cfg_req_i(req1), .cfg_gnt_o(gnt1), .cfg_add_i(add),
        .cfg_wen_i(wen), .cfg_data_i(data), .cfg_id_i(id), .cfg_r_data_o(rdata1),
        .cfg_r_valid_o(rvalid1), .cfg_r_id_o(rid1), .done_i(done1), .evt_i(evt_in),
        .start_o(start1), .busy_o(busy1), .ctx_o(ctx1), .acq_ctx_o(acq1), .locked_o(locked1),
        .evt_o(evt1), .sw_evt_o(sw1), .clear_o(clear1)
    );

    int checks = 0, errors = 0;
    logic [39:0] rq0[$], rq1[$];
    int st_ctx[$], st_cyc[$], ev_core[$], ev_cyc[$];
    int t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected required=none at cycle %0d", nm, cyc);
    endtask

    // response monitors
    always @(negedge clk) if (rst_ni) begin
        if (rvalid0) begin
            if (rq0.size() == 0) unexpected("rsp0");
            else chk("rsp0", {rid0, rdata0}, rq0.pop_front());
        end
        if (rvalid1) begin
            if (rq1.size() == 0) unexpected("rsp1");
            else chk("rsp1", {rid1, rdata1}, rq1.pop_front());
        end
    end

    // start and done-event monitors
    always @(negedge clk) if (rst_ni) begin
        int c, y;
        if (start0) begin
            if (st_ctx.size() == 0) unexpected("start");
            else begin
                c = st_ctx.pop_front();
                y = st_cyc.pop_front();
                chk("start_ctx", ctx0, c);
                if (y != 0) chk("start_cycle", cyc, y);
            end
        end
        for (int k = 0; k < 8; k++) if (evt0[k*4]) begin
            if (ev_core.size() == 0) unexpected("done_evt");
            else begin
                c = ev_core.pop_front();
                y = ev_cyc.pop_front();
                chk("done_evt_core", k, c);
                chk("done_evt_cycle", cyc, y);
            end
        end
    end

    task automatic acc(input bit u, input bit w, input logic [2:0] off, input logic [31:0] d,
                       input logic [7:0] i, input logic [31:0] exp, output int tt);
        @(posedge clk); #1;
        if (u) req1 = 1; else req0 = 1;
        wen = w; add = {27'd0, off, 2'b00}; data = d; id = i; tt = cyc;
        if (u) rq1.push_back({i, w ? exp : 32'h0});
        else rq0.push_back({i, w ? exp : 32'h0});
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
    endtask

    task automatic rd(input bit u, input logic [2:0] off, input logic [7:0] i, input logic [31:0] exp);
        int d;
        acc(u, 1'b1, off, 32'h0, i, exp, d);
    endtask

    task automatic wr(input bit u, input logic [2:0] off, input logic [31:0] d, input logic [7:0] i);
        int x;
        acc(u, 1'b0, off, d, i, 32'h0, x);
    endtask

    task automatic done_job(input int core, output int tt);
        @(posedge clk); #1;
        done0 = 1; tt = cyc;
        ev_core.push_back(core); ev_cyc.push_back(tt + 1);
        @(posedge clk); #1;
        done0 = 0;
    endtask

    task automatic wait_start();
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (start0) break;
        end
        if (n == 50) unexpected("wait_start_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt0, 1);
        chk("rst_start", start0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_locked", locked0, 0);
        chk("rst_evt", evt0, 0);
        chk("rst_sw", sw0, 0);
        chk("rst_clear", clear0, 0);
        chk("rst_rvalid", rvalid0, 0);
        @(posedge clk); #1;
        rst_ni = 1;

        // four jobs fill the queue, fifth acquire refused, events return in order
        for (int i = 0; i < 4; i++) begin
            rd(0, ACQ, 8'(i), 32'(i));
            acc(0, 1'b0, TRIG, 0, 8'(i), 0, t);
            if (i == 0) begin st_ctx.push_back(0); st_cyc.push_back(t + 2); end
        end
        rd(0, ACQ, 8'd4, 32'hFFFF_FFFF);
        rd(0, STAT, 8'd4, 32'h0003_0204);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_start();
            repeat (2) @(posedge clk);
            done_job(i, t);
            if (i < 3) begin st_ctx.push_back(i + 1); st_cyc.push_back(t + 3); end
        end
        repeat (2) @(posedge clk);
        rd(0, FIN, 8'd0, 32'd4);
        rd(0, RUNR, 8'd0, 32'd0);
        rd(0, STAT, 8'd0, 32'h0003_0000);

        // owner-checked trigger and abort
        rd(0, ACQ, 8'd1, 32'd0);
        chk("locked_after_acq", locked0, 1);
        chk("acq_ctx", acq0, 0);
        wr(0, TRIG, 0, 8'd3);
        rd(0, STAT, 8'd1, 32'h0001_0100);
        rd(0, ACQ, 8'd3, 32'hFFFF_FFFF);
        wr(0, ABRT, 0, 8'd3);
        rd(0, ACQ, 8'd3, 32'hFFFF_FFFF);
        wr(0, ABRT, 0, 8'd1);
        chk("unlocked_after_abort", locked0, 0);
        rd(0, ACQ, 8'd3, 32'd0);
        wr(0, ABRT, 0, 8'd3);
        rd(0, STAT, 8'd3, 32'h0003_0000);

        // trigger and done in the same cycle keep pending unchanged
        rd(0, ACQ, 8'd4, 32'd0);
        acc(0, 1'b0, TRIG, 0, 8'd4, 0, t);
        st_ctx.push_back(0); st_cyc.push_back(t + 2);
        rd(0, ACQ, 8'd5, 32'd1);
        wr(0, TRIG, 0, 8'd5);
        rd(0, ACQ, 8'd6, 32'd2);
        @(posedge clk); #1;
        req0 = 1; wen = 0; add = {27'd0, TRIG, 2'b00}; data = 0; id = 8'd6; done0 = 1; t = cyc;
        rq0.push_back({8'd6, 32'h0});
        ev_core.push_back(4); ev_cyc.push_back(t + 1);
        st_ctx.push_back(1); st_cyc.push_back(t + 3);
        @(posedge clk); #1;
        req0 = 0; done0 = 0;
        repeat (3) @(posedge clk);
        rd(0, STAT, 8'd6, 32'h0006_0202);
        done_job(5, t);
        st_ctx.push_back(2); st_cyc.push_back(t + 3);
        wait_start();
        repeat (2) @(posedge clk);
        done_job(6, t);
        repeat (2) @(posedge clk);
        rd(0, FIN, 8'd0, 32'd7);
        rd(0, RUNR, 8'd0, 32'd3);

        // soft clear during a running job
        rd(0, ACQ, 8'd7, 32'd3);
        acc(0, 1'b0, TRIG, 0, 8'd7, 0, t);
        st_ctx.push_back(3); st_cyc.push_back(t + 2);
        wait_start();
        repeat (2) @(posedge clk);
        wr(0, SCLR, 0, 8'd0);
        fork
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                chk($sformatf("clear_o_c%0d", k), clear0, k <= 3);
                if (k <= 3) chk($sformatf("busy_in_clear_c%0d", k), busy0, 0);
            end
            rd(0, ACQ, 8'd9, 32'hFFFF_FFFF);
        join
        @(posedge clk); #1; done0 = 1;
        @(posedge clk); #1; done0 = 0;
        rd(0, STAT, 8'd0, 32'h0);
        rd(0, FIN, 8'd0, 32'd0);
        rd(0, RUNR, 8'd0, 32'd0);

        // single job from core 2, done ten cycles after start
        rd(0, ACQ, 8'd2, 32'd0);
        acc(0, 1'b0, TRIG, 0, 8'd2, 0, t);
        st_ctx.push_back(0); st_cyc.push_back(t + 2);
        wait_start();
        repeat (9) @(posedge clk);
        done_job(2, t);
        repeat (3) @(posedge clk);
        rd(0, FIN, 8'd0, 32'd1);

        // software event
        wr(0, SWE, 32'd5, 8'd0);
        @(negedge clk);
        chk("sw_evt_pulse", sw0, 8'h20);
        @(negedge clk);
        chk("sw_evt_clear", sw0, 8'h00);

        // single-context instance
        rd(1, ACQ, 8'd0, 32'd0);
        wr(1, TRIG, 0, 8'd0);
        rd(1, ACQ, 8'd1, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        rd(1, STAT, 8'd0, 32'h0000_0201);

        // asynchronous reset mid-job
        rd(0, ACQ, 8'd0, 32'd1);
        acc(0, 1'b0, TRIG, 0, 8'd0, 0, t);
        st_ctx.push_back(1); st_cyc.push_back(t + 2);
        wait_start();
        repeat (2) @(posedge clk);
        #2 rst_ni = 0;
        #1;
        chk("async_rst_busy", busy0, 0);
        chk("async_rst_locked", locked0, 0);
        chk("async_rst_evt", evt0, 0);
        @(posedge clk); #1;
        rst_ni = 1;
        rd(0, RUNR, 8'd0, 32'd0);
        rd(0, FIN, 8'd0, 32'd0);

        repeat (5) @(posedge clk);
        chk("rsp0_left", rq0.size(), 0);
        chk("rsp1_left", rq1.size(), 0);
        chk("start_left", st_ctx.size(), 0);
        chk("evt_left", ev_core.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
